case_9_sdiv_7s_6s_7_seq: RTL and testbench

//  Iterative signed integer divider, the inverse of the 7s x 6s -> 7 multiplier core in case_9.

---
 rtl/case_9_sdiv_7s_6s_7_seq.sv | 151 +++++++++++++++
 tb/tb_case_9_sdiv_7s_6s_7_seq.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/case_9_sdiv_7s_6s_7_seq.sv
// Iterative signed divider (C semantics: quotient truncates toward zero, remainder follows dividend sign).
// One restoring step per enabled cycle; start/busy/done handshake with clock enable.
//
// state | meaning
// IDLE  | waiting for start; done pulses here for one enabled cycle
// CALC  | one restoring-division step per enabled edge, cnt steps remaining
// FIX   | apply signs and register quotient/remainder/div_by_zero
module case_9_sdiv_7s_6s_7_seq #(
    parameter int ID         = 1,
    parameter int din0_WIDTH = 7,
    parameter int din1_WIDTH = 6,
    parameter int dout_WIDTH = 7
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  start,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic                  busy,
    output logic                  done,
    output logic [dout_WIDTH-1:0] dout,
    output logic [din1_WIDTH-1:0] remainder,
    output logic                  div_by_zero
);

    localparam int W0 = din0_WIDTH;
    localparam int W1 = din1_WIDTH;
    localparam int CW = $clog2(din0_WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [CW-1:0] cnt;
    logic [W0-1:0] dvd;
    logic [W1:0]   dvs;
    logic [W1:0]   part;
    logic [W0-1:0] q_mag;
    logic          q_sign;
    logic          r_sign;
    logic          zero_div;
    logic [W1-1:0] din0_lo;

    // Magnitudes one bit wider so the most-negative operand is exact.
    logic [W0:0]   abs0;
    logic [W1:0]   abs1;
    logic [W1:0]   shifted;
    logic [W1:0]   diff;
    logic          fit;
    logic [dout_WIDTH-1:0] q_res;
    logic [W1-1:0] r_res;
    logic          unused_bits;

    assign abs0 = din0[W0-1] ? -{din0[W0-1], din0} : {din0[W0-1], din0};
    assign abs1 = din1[W1-1] ? -{din1[W1-1], din1} : {din1[W1-1], din1};

    assign shifted = {part[W1-1:0], dvd[W0-1]};
    assign fit     = (shifted >= dvs);
    assign diff    = shifted - dvs;

    // Negating the magnitude in dout width gives the wrap for most-negative / -1.
    assign q_res = q_sign ? dout_WIDTH'(-q_mag) : dout_WIDTH'(q_mag);
    assign r_res = r_sign ? -part[W1-1:0] : part[W1-1:0];

    assign unused_bits = ^{abs0[W0], part[W1], 1'(ID)};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else if (ce) begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = CALC;
            CALC: if (cnt == CW'(1)) state_nxt = FIX;
            FIX:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt         <= '0;
            dvd         <= '0;
            dvs         <= '0;
            part        <= '0;
            q_mag       <= '0;
            q_sign      <= 1'b0;
            r_sign      <= 1'b0;
            zero_div    <= 1'b0;
            din0_lo     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            dout        <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (ce) begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        dvd      <= abs0[W0-1:0];
                        dvs      <= abs1;
                        part     <= '0;
                        q_mag    <= '0;
                        q_sign   <= din0[W0-1] ^ din1[W1-1];
                        r_sign   <= din0[W0-1];
                        zero_div <= (din1 == '0);
                        din0_lo  <= din0[W1-1:0];
                        cnt      <= CW'(W0);
                        busy     <= 1'b1;
                    end
                end
                CALC: begin
                    dvd <= {dvd[W0-2:0], 1'b0};
                    cnt <= cnt - CW'(1);
                    if (fit) begin
                        part  <= diff;
                        q_mag <= {q_mag[W0-2:0], 1'b1};
                    end else begin
                        part  <= shifted;
                        q_mag <= {q_mag[W0-2:0], 1'b0};
                    end
                end
                FIX: begin
                    busy        <= 1'b0;
                    done        <= 1'b1;
                    div_by_zero <= zero_div;
                    if (zero_div) begin
                        dout      <= '1;
                        remainder <= din0_lo;
                    end else begin
                        dout      <= q_res;
                        remainder <= r_res;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_case_9_sdiv_7s_6s_7_seq.sv
// Self-checking bench for the iterative signed divider: directed cases plus a
// randomized back-to-back stream compared against C-style integer division.
module tb_case_9_sdiv_7s_6s_7_seq;

    logic       clk;
    logic       reset;
    logic       ce;
    logic       start;
    logic [6:0] din0;
    logic [5:0] din1;
    logic       busy;
    logic       done;
    logic [6:0] dout;
    logic [5:0] remainder;
    logic       div_by_zero;

    int errors = 0;
    int checks = 0;

    case_9_sdiv_7s_6s_7_seq dut (
        .clk(clk),
        .reset(reset),
        .ce(ce),
        .start(start),
        .din0(din0),
        .din1(din1),
        .busy(busy),
        .done(done),
        .dout(dout),
        .remainder(remainder),
        .div_by_zero(div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // C semantics: truncate toward zero, remainder takes dividend sign.
    function automatic void ref_div(input logic signed [6:0] a, input logic signed [5:0] b,
                                    output logic [6:0] q, output logic [5:0] r, output logic z);
        int ai;
        int bi;
        ai = a;
        bi = b;
        if (bi == 0) begin
            q = 7'h7f;
            r = a[5:0];
            z = 1'b1;
        end else begin
            q = 7'(ai / bi);
            r = 6'(ai % bi);
            z = 1'b0;
        end
    endfunction

    // Issue one divide and wait for done; returns observed edge count after the start edge.
    task automatic run_div(input int a, input int b, output int lat, output int busy_cycles);
        din0  = 7'(a);
        din1  = 6'(b);
        start = 1'b1;
        step();
        start = 1'b0;
        lat = 0;
        busy_cycles = 0;
        while (!done && lat < 60) begin
            if (busy) busy_cycles++;
            step();
            lat++;
        end
    endtask

    task automatic check_div(input string name, input int a, input int b,
                             input int eq, input int er, input logic ez);
        int lat;
        int bc;
        run_div(a, b, lat, bc);
        checks++;
        if (lat != 8 || done !== 1'b1) begin
            errors++;
            $display("FAIL %s latency: got %0d edges (done=%b), want 8", name, lat, done);
        end
        checks++;
        if (dout !== 7'(eq) || remainder !== 6'(er) || div_by_zero !== ez) begin
            errors++;
            $display("FAIL %s result: got q=%0d r=%0d z=%b, want q=%0d r=%0d z=%b", name,
                     $signed(dout), $signed(remainder), div_by_zero, eq, er, ez);
        end
        step();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        ce    = 1'b1;
        start = 1'b0;
        din0  = '0;
        din1  = '0;
        #23;
        checks++;
        if ({busy, done, dout, remainder, div_by_zero} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b done=%b q=%h r=%h z=%b, want all 0",
                     busy, done, dout, remainder, div_by_zero);
        end
        @(negedge clk);
        reset = 1'b0;
        step();
        step();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: got busy=%b done=%b, want 0 0", busy, done);
        end
    endtask

    task automatic test_basic();
        int lat;
        int bc;
        run_div(7, 2, lat, bc);
        checks++;
        if (lat != 8) begin
            errors++;
            $display("FAIL basic_latency: got %0d, want 8", lat);
        end
        checks++;
        if (bc != 8) begin
            errors++;
            $display("FAIL basic_busy_cycles: got %0d, want 8", bc);
        end
        checks++;
        if (dout !== 7'd3 || remainder !== 6'd1 || div_by_zero !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_result: got q=%0d r=%0d z=%b busy=%b, want 3 1 0 0",
                     $signed(dout), $signed(remainder), div_by_zero, busy);
        end
        step();
        checks++;
        if (done !== 1'b0 || dout !== 7'd3) begin
            errors++;
            $display("FAIL basic_pulse: got done=%b q=%0d, want done=0 q held 3", done, $signed(dout));
        end
    endtask

    task automatic test_signs();
        check_div("neg_pos", -7, 2, -3, -1, 1'b0);
        check_div("pos_neg", 7, -2, -3, 1, 1'b0);
        check_div("neg_neg", -7, -2, 3, -1, 1'b0);
        check_div("min_min32", -64, -32, 2, 0, 1'b0);
        check_div("max_min32", 63, -32, -1, 31, 1'b0);
    endtask

    task automatic test_edges();
        check_div("overflow", -64, -1, -64, 0, 1'b0);
        check_div("div_zero", 5, 0, -1, 5, 1'b1);
        check_div("div_zero_neg", -40, 0, -1, 24, 1'b1);
    endtask

    task automatic test_ce();
        int lat;
        din0  = 7'd50;
        din1  = 6'd7;
        start = 1'b1;
        step();
        start = 1'b0;
        lat = 0;
        while (!done && lat < 60) begin
            if (lat == 1) begin
                start = 1'b1;
                din0  = 7'd1;
                din1  = 6'd1;
            end else begin
                start = 1'b0;
            end
            ce = (lat >= 2 && lat < 5) ? 1'b0 : 1'b1;
            step();
            lat++;
        end
        ce = 1'b1;
        start = 1'b0;
        checks++;
        if (lat != 11) begin
            errors++;
            $display("FAIL ce_latency: got %0d, want 11", lat);
        end
        checks++;
        if (dout !== 7'd7 || remainder !== 6'd1) begin
            errors++;
            $display("FAIL ce_result: got q=%0d r=%0d, want 7 1", $signed(dout), $signed(remainder));
        end
        ce = 1'b0;
        step();
        step();
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL ce_done_hold: got done=%b, want 1", done);
        end
        ce = 1'b1;
        step();
        step();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL ce_no_extra_op: got done=%b busy=%b, want 0 0", done, busy);
        end
    endtask

    task automatic test_reset_mid();
        int seen_done;
        din0  = 7'd33;
        din1  = 6'd5;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        step();
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({busy, done, dout, remainder, div_by_zero} !== '0) begin
            errors++;
            $display("FAIL reset_mid_outputs: got busy=%b done=%b q=%h r=%h z=%b, want all 0",
                     busy, done, dout, remainder, div_by_zero);
        end
        step();
        step();
        @(negedge clk);
        reset = 1'b0;
        seen_done = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (done || busy) seen_done++;
        end
        checks++;
        if (seen_done != 0) begin
            errors++;
            $display("FAIL reset_mid_no_done: got %0d active cycles, want 0", seen_done);
        end
        check_div("after_reset", 20, 3, 6, 2, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [6:0] qa [$];
        logic [5:0] qb [$];
        logic [6:0] a;
        logic [5:0] b;
        logic [6:0] eq;
        logic [5:0] er;
        logic ez;
        int issued;
        int results;
        int edge_no;
        int last_done;
        int bad_space;
        int bad_res;
        a = 7'($urandom_range(0, 127));
        b = 6'($urandom_range(0, 63));
        qa.push_back(a);
        qb.push_back(b);
        issued = 1;
        din0  = a;
        din1  = b;
        start = 1'b1;
        step();
        edge_no = 0;
        last_done = -1;
        results = 0;
        bad_space = 0;
        bad_res = 0;
        while (results < 100 && edge_no < 2000) begin
            if (done) begin
                ref_div(qa.pop_front(), qb.pop_front(), eq, er, ez);
                if (dout !== eq || remainder !== er || div_by_zero !== ez) begin
                    bad_res++;
                    if (bad_res <= 5)
                        $display("FAIL b2b_result #%0d: got q=%0d r=%0d z=%b, want q=%0d r=%0d z=%b",
                                 results, $signed(dout), $signed(remainder), div_by_zero,
                                 $signed(eq), $signed(er), ez);
                end
                if (last_done >= 0 && edge_no - last_done != 9) begin
                    bad_space++;
                    if (bad_space <= 5)
                        $display("FAIL b2b_spacing #%0d: got %0d cycles, want 9", results, edge_no - last_done);
                end
                last_done = edge_no;
                results++;
                if (issued < 100) begin
                    a = 7'($urandom_range(0, 127));
                    b = 6'($urandom_range(0, 63));
                    if (issued % 25 == 0) b = 6'd0;
                    qa.push_back(a);
                    qb.push_back(b);
                    din0 = a;
                    din1 = b;
                    issued++;
                end else begin
                    start = 1'b0;
                end
            end
            step();
            edge_no++;
        end
        start = 1'b0;
        checks++;
        if (results != 100) begin
            errors++;
            $display("FAIL b2b_count: got %0d results, want 100", results);
        end
        checks++;
        if (bad_res != 0) begin
            errors++;
            $display("FAIL b2b_results: got %0d wrong results, want 0", bad_res);
        end
        checks++;
        if (bad_space != 0) begin
            errors++;
            $display("FAIL b2b_spacing_total: got %0d bad gaps, want 0", bad_space);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signs();
        test_edges();
        test_ce();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
